// File: rtl/sysbus_arbiter_n_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sysbus_arb_pkg                                         |
// | Description : Shared types and helpers for the N-client Sysbus       |
// |               arbiter.                                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sysbus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HDR   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RRESP = 2'd3
   } arb_state_t;

   localparam logic OP_READ       = 1'b1;
   localparam int   MAX_TAG_WIDTH = 64;
   localparam int   TAG_IDX_W     = $clog2(MAX_TAG_WIDTH);

   // The op bit is the MSB of a tag_width-wide tag (zero-extended into tag).
   function automatic logic op_bit(input logic [MAX_TAG_WIDTH-1:0] tag,
                                   input int unsigned tag_width);
      return tag[TAG_IDX_W'(tag_width - 1)];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sysbus_arbiter_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sysbus_arb_if                                          |
// | Description : Client-side and Sysbus-side signals of the arbiter.    |
// |               master = the arbiter (it masters the Sysbus port),     |
// |               slave  = the clients plus the Sysbus memory side.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface sysbus_arb_if #(
   parameter int WIDTH     = 64,
   parameter int TAG_WIDTH = 13,
   parameter int N_CLIENTS = 2
);
   // Client side, flat per-client vectors
   logic [N_CLIENTS-1:0]           cl_reqcyc;
   logic [N_CLIENTS*WIDTH-1:0]     cl_req;
   logic [N_CLIENTS*TAG_WIDTH-1:0] cl_reqtag;
   logic [N_CLIENTS-1:0]           cl_reqack;
   logic [N_CLIENTS-1:0]           cl_respcyc;
   logic [WIDTH-1:0]               cl_resp;
   logic [TAG_WIDTH-1:0]           cl_resptag;
   logic [N_CLIENTS-1:0]           cl_writeack;

   // Sysbus side
   logic                           bus_reqcyc;
   logic [WIDTH-1:0]               bus_req;
   logic [TAG_WIDTH-1:0]           bus_reqtag;
   logic                           bus_reqack;
   logic                           bus_respcyc;
   logic [WIDTH-1:0]               bus_resp;
   logic [TAG_WIDTH-1:0]           bus_resptag;
   logic                           bus_respack;

   modport master (
      input  cl_reqcyc, cl_req, cl_reqtag,
      output cl_reqack, cl_respcyc, cl_resp, cl_resptag, cl_writeack,
      output bus_reqcyc, bus_req, bus_reqtag,
      input  bus_reqack,
      input  bus_respcyc, bus_resp, bus_resptag,
      output bus_respack
   );

   modport slave (
      output cl_reqcyc, cl_req, cl_reqtag,
      input  cl_reqack, cl_respcyc, cl_resp, cl_resptag, cl_writeack,
      input  bus_reqcyc, bus_req, bus_reqtag,
      output bus_reqack,
      output bus_respcyc, bus_resp, bus_resptag,
      input  bus_respack
   );
endinterface
`default_nettype wire

// File: rtl/sysbus_arbiter_n_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_pick                                                |
// | Description : Combinational N-way picker. Scans the request vector   |
// |               starting just after the previous winner, wrapping.     |
// |               With rr_mode=0 the start is pinned to N-1, which       |
// |               degenerates to fixed priority (lowest index wins).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   input  logic                 rr_mode,
   output logic [N-1:0]         gnt_oh,
   output logic [$clog2(N)-1:0] gnt_idx
);
   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] start;
   logic             found;
   int               cand;

   // First set request strictly after start, wrapping, wins.
   always_comb begin
      start   = rr_mode ? last : IDX_W'(N - 1);
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(start) + k) % N;
         if (!found && req[IDX_W'(cand)]) begin
            found                = 1'b1;
            gnt_oh[IDX_W'(cand)] = 1'b1;
            gnt_idx              = IDX_W'(cand);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/sysbus_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sysbus_arbiter_n                                       |
// | Description : N-client arbiter in front of the single Sysbus port.   |
// |               Grants one client at a time, forwards its header and   |
// |               write beats, steers read beats back to the owner and   |
// |               pulses a per-client write-complete.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sysbus_arbiter_n
   import sysbus_arb_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int TAG_WIDTH = 13,
   parameter int N_CLIENTS = 2,
   parameter int BEATS     = 8,
   parameter int RR        = 0
) (
   input  logic         clk,
   input  logic         reset,
   sysbus_arb_if.master bus_if
);
   localparam int               IDX_W     = $clog2(N_CLIENTS);
   localparam int               CNT_W     = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [N_CLIENTS-1:0] writeack_q, writeack_d;

   logic [WIDTH-1:0]     req_arr [N_CLIENTS];
   logic [TAG_WIDTH-1:0] tag_arr [N_CLIENTS];
   logic                 gnt_reqcyc;
   logic [WIDTH-1:0]     gnt_req;
   logic [TAG_WIDTH-1:0] gnt_tag;
   logic                 fwd_req;
   logic                 beat_req;
   logic                 beat_resp;
   logic [N_CLIENTS-1:0] pick_oh;
   logic [IDX_W-1:0]     pick_idx;

   // Split the flat client buses into per-client slots
   for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
      assign req_arr[i] = bus_if.cl_req[i*WIDTH +: WIDTH];
      assign tag_arr[i] = bus_if.cl_reqtag[i*TAG_WIDTH +: TAG_WIDTH];
   end

   assign gnt_reqcyc = bus_if.cl_reqcyc[grant_q];
   assign gnt_req    = req_arr[grant_q];
   assign gnt_tag    = tag_arr[grant_q];

   rr_pick #(.N(N_CLIENTS)) u_pick (
      .req     (bus_if.cl_reqcyc),
      .last    (last_grant_q),
      .rr_mode (RR != 0),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx)
   );

   // A request beat only counts when the owner is still driving it, so a
   // client that drops reqcyc mid-transaction simply stalls it.
   assign fwd_req   = (state_q == ST_HDR) || (state_q == ST_WDATA);
   assign beat_req  = fwd_req && gnt_reqcyc && bus_if.bus_reqack;
   assign beat_resp = (state_q == ST_RRESP) && bus_if.bus_respcyc;

   // Output muxes: pass the owner's request through, steer responses back.
   always_comb begin
      bus_if.bus_reqcyc          = fwd_req && gnt_reqcyc;
      bus_if.bus_req             = fwd_req ? gnt_req : '0;
      bus_if.bus_reqtag          = fwd_req ? gnt_tag : '0;
      bus_if.cl_reqack           = '0;
      bus_if.cl_reqack[grant_q]  = beat_req;
      bus_if.bus_respack         = beat_resp;
      bus_if.cl_respcyc          = '0;
      bus_if.cl_respcyc[grant_q] = beat_resp;
      bus_if.cl_resp             = beat_resp ? bus_if.bus_resp : '1;
      bus_if.cl_resptag          = beat_resp ? bus_if.bus_resptag : '0;
      bus_if.cl_writeack         = writeack_q;
   end

   // Next-state logic for the FSM, beat counter and write-complete pulse.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      writeack_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (|pick_oh) begin
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               state_d      = ST_HDR;
            end
         end
         ST_HDR: begin
            if (beat_req) begin
               beat_cnt_d = '0;
               state_d    = (op_bit(MAX_TAG_WIDTH'(gnt_tag), TAG_WIDTH) == OP_READ)
                            ? ST_RRESP : ST_WDATA;
            end
         end
         ST_WDATA: begin
            if (beat_req) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  writeack_d[grant_q] = 1'b1;
                  state_d             = ST_IDLE;
               end
            end
         end
         ST_RRESP: begin
            if (beat_resp) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All arbiter state, with synchronous reset abandoning any transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(N_CLIENTS - 1);
         beat_cnt_q   <= '0;
         writeack_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         writeack_q   <= writeack_d;
      end
   end

   // A response beat with no read in flight has no owner and is dropped.
   a_no_spurious_resp : assert property (@(posedge clk) disable iff (reset)
      bus_if.bus_respcyc |-> (state_q == ST_RRESP))
      else $warning("sysbus_arbiter_n: bus_respcyc outside RRESP dropped");

endmodule
`default_nettype wire
